// File: rtl/thor2021_pkg.sv
// thor2021_pkg: shared slot type and constants for the Thor2021 memory request tracker
// Contents:
//   RTW          destination register field width
//   WB_DATA_ZERO fill bit for writeback data of store entries
//   mem_tag_t    per-slot state: valid, done, load, rt, err
package thor2021_pkg;
  localparam int RTW = 6;
  localparam logic WB_DATA_ZERO = 1'b0;
  // tid, dat and timer widths follow the tracker parameters, so those slot
  // fields are held in parameter-sized arrays alongside this struct
  typedef struct packed {
    logic valid;
    logic done;
    logic load;
    logic [RTW-1:0] rt;
    logic err;
  } mem_tag_t;
endpackage

// File: rtl/thor2021_ffo.sv
// thor2021_ffo: find-first-one priority encoder, lowest set index wins
// Ports:
//   req  in  N     request vector
//   idx  out W     index of the lowest set bit (0 when none set)
module thor2021_ffo #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
endmodule

// File: rtl/thor2021_memreq_tracker.sv
// thor2021_memreq_tracker: tracks NTAGS outstanding BIU requests by tid and presents completions for writeback
// Ports:
//   clk_i, rst_i (async active-low)       clock and reset
//   flush_i                               discard every outstanding slot
//   req_v_i/req_rdy_o/req_load_i/req_rt_i request from execute; req_tid_o is its tid
//   resp_v_i/resp_tid_i/resp_dat_i/resp_err_i  BIU response
//   wb_v_o/wb_rdy_i/wb_load_o/wb_rt_o/wb_tid_o/wb_dat_o/wb_err_o  completed entry
//   count_o                               slots in use
//   stray_o, timeout_o                    one-cycle event pulses
module thor2021_memreq_tracker
  import thor2021_pkg::*;
#(
  parameter int NTAGS    = 4,
  parameter int TIDW     = 8,
  parameter int DATW     = 64,
  parameter int IN_ORDER = 1,
  parameter int TIMEOUT  = 1023
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   req_v_i,
  output logic                   req_rdy_o,
  input  logic                   req_load_i,
  input  logic [5:0]             req_rt_i,
  output logic [TIDW-1:0]        req_tid_o,
  input  logic                   resp_v_i,
  input  logic [TIDW-1:0]        resp_tid_i,
  input  logic [DATW-1:0]        resp_dat_i,
  input  logic                   resp_err_i,
  output logic                   wb_v_o,
  input  logic                   wb_rdy_i,
  output logic                   wb_load_o,
  output logic [5:0]             wb_rt_o,
  output logic [TIDW-1:0]        wb_tid_o,
  output logic [DATW-1:0]        wb_dat_o,
  output logic                   wb_err_o,
  output logic [$clog2(NTAGS):0] count_o,
  output logic                   stray_o,
  output logic                   timeout_o
);
  localparam int IW = $clog2(NTAGS);
  localparam int CW = IW + 1;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  mem_tag_t [NTAGS-1:0]       ctl_q, ctl_d;
  logic [NTAGS-1:0][TIDW-1:0] tid_q, tid_d;
  logic [NTAGS-1:0][DATW-1:0] dat_q, dat_d;
  logic [NTAGS-1:0][TW-1:0]   tmr_q, tmr_d;
  logic [NTAGS-1:0]           free_vec, match_vec, ready_vec;
  logic [TIDW-1:0]            tid_cnt_q;
  logic [IW-1:0]              head_q, head_d, tail_q, sel_q, sel_d, free_idx, ready_idx, alloc;
  logic [CW-1:0]              count_q;
  logic                       wb_v_q, wb_v_d, stray_q, tmo_q, tmo_hit, acc, ret, hold;

  assign req_rdy_o = !flush_i && count_q < CW'(NTAGS);
  assign acc       = req_v_i && req_rdy_o;
  assign ret       = wb_v_q && wb_rdy_i && !flush_i;
  assign hold      = wb_v_q && !wb_rdy_i;
  assign alloc     = IN_ORDER != 0 ? tail_q : free_idx;
  assign head_d    = flush_i ? '0 : head_q + IW'(ret);

  always_comb begin
    for (int i = 0; i < NTAGS; i++) begin
      free_vec[i]  = !ctl_q[i].valid;
      match_vec[i] = resp_v_i && ctl_q[i].valid && !ctl_q[i].done && tid_q[i] == resp_tid_i;
    end
  end

  thor2021_ffo #(.N(NTAGS)) u_free (.req(free_vec), .idx(free_idx));

  // A response beats a timeout on the same slot; the new slot state also
  // feeds writeback selection so a completion is presented one edge later.
  always_comb begin
    ctl_d   = ctl_q;
    tid_d   = tid_q;
    dat_d   = dat_q;
    tmr_d   = tmr_q;
    tmo_hit = 1'b0;
    for (int i = 0; i < NTAGS; i++) begin
      if (match_vec[i]) begin
        ctl_d[i].done = 1'b1;
        ctl_d[i].err  = resp_err_i;
        dat_d[i]      = resp_dat_i;
      end else if (TIMEOUT != 0 && ctl_q[i].valid && !ctl_q[i].done) begin
        if (tmr_q[i] >= TMO_LAST) begin
          ctl_d[i].done = 1'b1;
          ctl_d[i].err  = 1'b1;
          tmo_hit       = 1'b1;
        end else begin
          tmr_d[i] = tmr_q[i] + TW'(1);
        end
      end
    end
    if (ret) ctl_d[sel_q].valid = 1'b0;
    if (acc) begin
      ctl_d[alloc] = '{valid: 1'b1, done: 1'b0, load: req_load_i, rt: req_rt_i, err: 1'b0};
      tid_d[alloc] = tid_cnt_q;
      dat_d[alloc] = '0;
      tmr_d[alloc] = TW'(1);
    end
    if (flush_i) for (int i = 0; i < NTAGS; i++) ctl_d[i].valid = 1'b0;
    for (int i = 0; i < NTAGS; i++) ready_vec[i] = ctl_d[i].valid && ctl_d[i].done;
  end

  thor2021_ffo #(.N(NTAGS)) u_ready (.req(ready_vec), .idx(ready_idx));

  // The presented slot is locked while the consumer stalls, even if a
  // lower-index slot completes meanwhile.
  always_comb begin
    sel_d  = hold ? sel_q : IN_ORDER != 0 ? head_d : ready_idx;
    wb_v_d = !flush_i && (hold || (IN_ORDER != 0 ? ready_vec[head_d] : |ready_vec));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctl_q     <= '0;
      tid_q     <= '0;
      dat_q     <= '0;
      tmr_q     <= '0;
      tid_cnt_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      sel_q     <= '0;
      count_q   <= '0;
      wb_v_q    <= 1'b0;
      stray_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      ctl_q     <= ctl_d;
      tid_q     <= tid_d;
      dat_q     <= dat_d;
      tmr_q     <= tmr_d;
      tid_cnt_q <= tid_cnt_q + TIDW'(acc);
      head_q    <= head_d;
      tail_q    <= flush_i ? '0 : tail_q + IW'(acc);
      sel_q     <= sel_d;
      count_q   <= flush_i ? '0 : count_q + CW'(acc) - CW'(ret);
      wb_v_q    <= wb_v_d;
      stray_q   <= resp_v_i && !(|match_vec) && !flush_i;
      tmo_q     <= tmo_hit && !flush_i;
    end
  end

  assign req_tid_o = tid_cnt_q;
  assign wb_v_o    = wb_v_q;
  assign wb_load_o = ctl_q[sel_q].load;
  assign wb_rt_o   = ctl_q[sel_q].rt;
  assign wb_tid_o  = tid_q[sel_q];
  assign wb_dat_o  = ctl_q[sel_q].load ? dat_q[sel_q] : {DATW{WB_DATA_ZERO}};
  assign wb_err_o  = ctl_q[sel_q].err;
  assign count_o   = count_q;
  assign stray_o   = stray_q;
  assign timeout_o = tmo_q;
endmodule

// File: tb/tb_thor2021_memreq_tracker.sv
// tb_thor2021_memreq_tracker: scoreboard bench over in-order, out-of-order and short-timeout trackers
module tb_thor2021_memreq_tracker;
  typedef struct packed {
    logic load;
    logic [5:0] rt;
    logic [7:0] tid;
    logic [63:0] dat;
    logic err;
  } wb_t;

  logic clk_i = 1'b0, rst_i = 1'b0, flush_i = 1'b0, req_v_i = 1'b0, req_load_i = 1'b0;
  logic resp_v_i = 1'b0, resp_err_i = 1'b0, wb_rdy_i = 1'b1;
  logic [5:0] req_rt_i = '0;
  logic [7:0] resp_tid_i = '0;
  logic [63:0] resp_dat_i = '0;

  logic req_rdy [3];
  logic [7:0] req_tid [3];
  logic wb_v [3], wb_load [3], wb_err [3], stray [3], tmo [3];
  logic [5:0] wb_rt [3];
  logic [7:0] wb_tid [3];
  logic [63:0] wb_dat [3];
  logic [2:0] count [3];

  int vecs = 0, errs = 0, act = 0, n_stray = 0, n_tmo = 0;
  wb_t exp_q[$];

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    thor2021_memreq_tracker #(
      .NTAGS(4), .TIDW(8), .DATW(64),
      .IN_ORDER(g == 1 ? 0 : 1), .TIMEOUT(g == 2 ? 8 : 1023)
    ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .req_v_i(req_v_i), .req_rdy_o(req_rdy[g]), .req_load_i(req_load_i),
      .req_rt_i(req_rt_i), .req_tid_o(req_tid[g]),
      .resp_v_i(resp_v_i), .resp_tid_i(resp_tid_i), .resp_dat_i(resp_dat_i), .resp_err_i(resp_err_i),
      .wb_v_o(wb_v[g]), .wb_rdy_i(wb_rdy_i), .wb_load_o(wb_load[g]), .wb_rt_o(wb_rt[g]),
      .wb_tid_o(wb_tid[g]), .wb_dat_o(wb_dat[g]), .wb_err_o(wb_err[g]),
      .count_o(count[g]), .stray_o(stray[g]), .timeout_o(tmo[g])
    );
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Every cycle an entry is presented it must equal the scoreboard head,
  // which also proves it stays put while the consumer stalls.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (stray[act]) n_stray++;
      if (tmo[act]) n_tmo++;
      if (wb_v[act]) begin
        if (exp_q.size() == 0) check("wb_unexpected", 64'd1, 64'd0);
        else begin
          check("wb_load", wb_load[act], exp_q[0].load);
          check("wb_rt", wb_rt[act], exp_q[0].rt);
          check("wb_tid", wb_tid[act], exp_q[0].tid);
          check("wb_dat", wb_dat[act], exp_q[0].dat);
          check("wb_err", wb_err[act], exp_q[0].err);
          if (wb_rdy_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut(input int which);
    act = which;
    rst_i = 1'b0; flush_i = 1'b0; req_v_i = 1'b0; resp_v_i = 1'b0; resp_err_i = 1'b0; wb_rdy_i = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    n_stray = 0;
    n_tmo = 0;
    #1;
    check("rst_rdy", req_rdy[act], 1);
    check("rst_tid", req_tid[act], 0);
    check("rst_count", count[act], 0);
    check("rst_wb_v", wb_v[act], 0);
    check("rst_wb_err", wb_err[act], 0);
    check("rst_stray", stray[act], 0);
    check("rst_tmo", tmo[act], 0);
  endtask

  task automatic req(input logic load, input logic [5:0] rt, input logic [7:0] exp_tid);
    req_v_i = 1'b1; req_load_i = load; req_rt_i = rt;
    #1;
    check("req_rdy", req_rdy[act], 1);
    check("req_tid", req_tid[act], exp_tid);
    tick();
    req_v_i = 1'b0;
  endtask

  task automatic resp(input logic [7:0] tid, input logic [63:0] dat, input logic err);
    resp_v_i = 1'b1; resp_tid_i = tid; resp_dat_i = dat; resp_err_i = err;
    tick();
    resp_v_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // in-order retire
    reset_dut(0);
    for (int k = 0; k < 4; k++) req(1'b1, 6'(k + 1), 8'(k));
    req_v_i = 1'b1; req_rt_i = 6'd5;
    #1;
    check("full_rdy", req_rdy[act], 0);
    check("full_count", count[act], 4);
    tick();
    req_v_i = 1'b0;
    #1;
    check("fifth_count", count[act], 4);
    check("fifth_tid", req_tid[act], 4);
    exp_q.push_back('{1'b1, 6'd1, 8'd0, 64'h00, 1'b0});
    exp_q.push_back('{1'b1, 6'd2, 8'd1, 64'h10, 1'b0});
    exp_q.push_back('{1'b1, 6'd3, 8'd2, 64'h20, 1'b0});
    exp_q.push_back('{1'b1, 6'd4, 8'd3, 64'h30, 1'b0});
    resp(8'd2, 64'h20, 1'b0);
    resp(8'd0, 64'h00, 1'b0);
    resp(8'd3, 64'h30, 1'b0);
    resp(8'd1, 64'h10, 1'b0);
    drain();
    tick();
    check("io_count", count[act], 0);
    check("io_stray", n_stray, 0);

    // out-of-order retire with a stall on the third entry
    reset_dut(1);
    for (int k = 0; k < 4; k++) req(1'b1, 6'(k + 1), 8'(k));
    exp_q.push_back('{1'b1, 6'd3, 8'd2, 64'h20, 1'b0});
    exp_q.push_back('{1'b1, 6'd1, 8'd0, 64'h00, 1'b0});
    exp_q.push_back('{1'b1, 6'd4, 8'd3, 64'h30, 1'b0});
    exp_q.push_back('{1'b1, 6'd2, 8'd1, 64'h10, 1'b0});
    resp(8'd2, 64'h20, 1'b0);
    resp(8'd0, 64'h00, 1'b0);
    resp(8'd3, 64'h30, 1'b0);
    wb_rdy_i = 1'b0;
    resp(8'd1, 64'h10, 1'b0);
    check("ooo_hold_count", count[act], 2);
    check("ooo_hold_v", wb_v[act], 1);
    tick();
    tick();
    wb_rdy_i = 1'b1;
    drain();

    // stray responses and store data forcing
    reset_dut(0);
    wb_rdy_i = 1'b0;
    req(1'b1, 6'd7, 8'd0);
    req(1'b0, 6'd9, 8'd1);
    exp_q.push_back('{1'b1, 6'd7, 8'd0, 64'hAB, 1'b0});
    exp_q.push_back('{1'b0, 6'd9, 8'd1, 64'h0, 1'b0});
    resp(8'h55, 64'h1234, 1'b0);
    resp(8'd0, 64'hAB, 1'b0);
    resp(8'd0, 64'hCD, 1'b0);
    resp(8'd1, 64'hFFFF, 1'b0);
    tick();
    tick();
    check("stray_count", n_stray, 2);
    check("stray_slots", count[act], 2);
    wb_rdy_i = 1'b1;
    drain();

    // timeout
    reset_dut(2);
    exp_q.push_back('{1'b1, 6'd12, 8'd0, 64'h0, 1'b1});
    req(1'b1, 6'd12, 8'd0);
    begin
      int k = 1;
      while (!tmo[act] && k < 20) begin
        tick();
        k++;
      end
      check("tmo_cycle", k, 8);
    end
    tick();
    tick();
    resp(8'd0, 64'h99, 1'b0);
    tick();
    check("tmo_late_stray", n_stray, 1);
    check("tmo_pulses", n_tmo, 1);
    check("tmo_count", count[act], 0);
    drain();

    // flush
    reset_dut(0);
    for (int k = 0; k < 3; k++) req(1'b1, 6'(k + 1), 8'(k));
    flush_i = 1'b1; req_v_i = 1'b1; req_rt_i = 6'd30;
    resp_v_i = 1'b1; resp_tid_i = 8'd1; resp_dat_i = 64'h10;
    #1;
    check("flush_rdy", req_rdy[act], 0);
    tick();
    flush_i = 1'b0; req_v_i = 1'b0; resp_v_i = 1'b0;
    #1;
    check("flush_count", count[act], 0);
    check("flush_wb_v", wb_v[act], 0);
    req(1'b1, 6'd20, 8'd3);
    resp(8'd1, 64'h10, 1'b0);
    exp_q.push_back('{1'b1, 6'd20, 8'd3, 64'h77, 1'b0});
    resp(8'd3, 64'h77, 1'b0);
    drain();
    check("flush_stray", n_stray, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
